// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: opcodes, the buffered
// result record and the occupancy states.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] y;
    logic [3:0]           op;
    logic                 zero;
    logic                 neg;
    logic                 carry;
    logic                 ovf;
  } alu_entry_t;

  // Everything in an entry except the data word, so storage can follow WIDTH.
  typedef struct packed {
    logic [3:0] op;
    logic       zero;
    logic       neg;
    logic       carry;
    logic       ovf;
  } alu_meta_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready result bus between an ALU unit, the result stage and its consumer.
interface alu_result_stage_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic [3:0]       in_op;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_y, in_op, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_zero, out_neg, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_y, in_op, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_y, out_op, out_zero, out_neg, out_carry, out_ovf
  );
endinterface

// File: rtl/alu_flags.sv
// Zero/negative flag generation for an incoming result word.
module alu_flags import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] y_i,
  output logic             zero_o,
  output logic             neg_o
);
  assign zero_o = (y_i == '0);
  assign neg_o  = y_i[WIDTH-1];
endmodule

// File: rtl/alu_result_stage.sv
// Two-entry FIFO skid stage for ALU results; flags are computed on capture and
// all outputs come from registers, so neither side sees a combinational path.
module alu_result_stage import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus,
  output logic [1:0]          count,
  output logic [15:0]         pop_cnt
);

  occ_state_e       state_q;
  logic [1:0]       count_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [15:0]      pop_cnt_q;
  logic [15:0]      pop_cnt_d;
  logic [WIDTH-1:0] y_q    [DEPTH];
  alu_meta_t        meta_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             in_zero;
  logic             in_neg;
  logic             push;
  logic             pop;

  assign push      = bus.in_valid && in_ready_q;
  assign pop       = out_valid_q && bus.out_ready;
  assign pop_cnt_d = pop_cnt_q + 16'd1;

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .y_i    (bus.in_y),
    .zero_o (in_zero),
    .neg_o  (in_neg)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
  end

  // in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            state_q     <= ST_ONE;
            count_q     <= 2'd1;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          in_ready_q <= !(push && !pop);
          if (push && !pop) begin
            state_q <= ST_FULL;
            count_q <= 2'd2;
          end else if (pop && !push) begin
            state_q     <= ST_EMPTY;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_q    <= ST_ONE;
            count_q    <= 2'd1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          count_q     <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      pop_cnt_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        y_q[i]    <= '0;
        meta_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          y_q[i]    <= bus.in_y;
          meta_q[i] <= '{op: bus.in_op, zero: in_zero, neg: in_neg,
                         carry: bus.in_carry, ovf: bus.in_ovf};
        end
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        pop_cnt_q <= pop_cnt_d;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = y_q[rd_ptr_q];
  assign bus.out_op    = meta_q[rd_ptr_q].op;
  assign bus.out_zero  = meta_q[rd_ptr_q].zero;
  assign bus.out_neg   = meta_q[rd_ptr_q].neg;
  assign bus.out_carry = meta_q[rd_ptr_q].carry;
  assign bus.out_ovf   = meta_q[rd_ptr_q].ovf;
  assign count         = count_q;
  assign pop_cnt       = pop_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scenario bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  count;
  logic [15:0] pop_cnt;

  alu_result_stage_if #(.WIDTH(32)) bus ();

  alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .count   (count),
    .pop_cnt (pop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  alu_entry_t mq[$];
  int         m_pops  = 0;
  bit         m_fresh = 1'b1;
  bit         last_push, last_pop;

  // Applies one cycle of inputs at a falling edge, advances the model across
  // the rising edge and returns at the next falling edge.
  task automatic step(input bit v, input logic [31:0] y, input logic [3:0] op,
                      input bit c, input bit o, input bit rdy);
    bit m_push, m_pop;
    alu_entry_t e;
    bus.in_valid  = v;
    bus.in_y      = y;
    bus.in_op     = op;
    bus.in_carry  = c;
    bus.in_ovf    = o;
    bus.out_ready = rdy;
    m_push = v && !m_fresh && (mq.size() != 2);
    m_pop  = (mq.size() != 0) && rdy;
    @(posedge clk);
    if (m_pop) begin
      void'(mq.pop_front());
      m_pops = (m_pops + 1) % 65536;
    end
    if (m_push) begin
      e.y     = y;
      e.op    = op;
      e.zero  = (y == 32'd0);
      e.neg   = (y >= 32'h8000_0000);
      e.carry = c;
      e.ovf   = o;
      mq.push_back(e);
    end
    m_fresh   = 1'b0;
    last_push = m_push;
    last_pop  = m_pop;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pops  = 0;
    m_fresh = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_y = '0; bus.in_op = '0;
    bus.in_carry = 1'b0; bus.in_ovf = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (pop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_pop_cnt: got %h expected 0000", pop_cnt); end
    n_cmp++; if (bus.out_y !== 32'd0) begin n_err++; $display("FAIL rst_out_y: got %h expected 00000000", bus.out_y); end
    n_cmp++;
    if ({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf, bus.out_op} !== 8'd0) begin
      n_err++; $display("FAIL rst_flags: got %b expected 00000000",
                        {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf, bus.out_op});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_single();
    step(1'b1, 32'hA5A5_A5A5, ALU_AND, 1'b0, 1'b0, 1'b1);
    $display("txn single push y=a5a5a5a5");
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_y !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL single_y: got %h expected a5a5a5a5", bus.out_y); end
    n_cmp++; if (bus.out_neg !== 1'b1 || bus.out_zero !== 1'b0) begin
      n_err++; $display("FAIL single_flags: got neg=%b zero=%b expected neg=1 zero=0", bus.out_neg, bus.out_zero); end
    n_cmp++; if (bus.out_op !== ALU_AND) begin n_err++; $display("FAIL single_op: got %0d expected %0d", bus.out_op, ALU_AND); end
    idle(1'b1);
    n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL single_count: got %0d expected 0", count); end
    n_cmp++; if (pop_cnt !== 16'd1) begin n_err++; $display("FAIL single_pop_cnt: got %h expected 0001", pop_cnt); end
  endtask

  task automatic test_full_order();
    step(1'b1, 32'h0000_0000, ALU_OR, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, ALU_XOR, 1'b0, 1'b0, 1'b0);
    $display("txn full_order pushed 00000000, ffffffff");
    n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL order_count: got %0d expected 2", count); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL order_in_ready: got %b expected 0", bus.in_ready); end
    idle(1'b0);
    n_cmp++; if (bus.out_y !== 32'd0 || bus.out_zero !== 1'b1) begin
      n_err++; $display("FAIL order_head_held: got y=%h zero=%b expected y=00000000 zero=1", bus.out_y, bus.out_zero); end
    idle(1'b1);
    n_cmp++; if (bus.out_y !== 32'hFFFF_FFFF || bus.out_neg !== 1'b1) begin
      n_err++; $display("FAIL order_second: got y=%h neg=%b expected y=ffffffff neg=1", bus.out_y, bus.out_neg); end
    n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL order_count_after_pop: got %0d expected 1", count); end
    idle(1'b1);
    n_cmp++; if (pop_cnt !== 16'd3) begin n_err++; $display("FAIL order_pop_cnt: got %h expected 0003", pop_cnt); end
  endtask

  task automatic test_full_refuse();
    step(1'b1, 32'h1111_1111, ALU_ADD, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0000, ALU_SUB, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, ALU_AND, 1'b0, 1'b0, 1'b1);
    $display("txn full_refuse offered deadbeef while full");
    n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL refuse_count: got %0d expected 1", count); end
    n_cmp++; if (bus.out_y !== 32'h8000_0000 || bus.out_ovf !== 1'b1 || bus.out_op !== ALU_SUB) begin
      n_err++; $display("FAIL refuse_head: got y=%h ovf=%b op=%0d expected y=80000000 ovf=1 op=4",
                        bus.out_y, bus.out_ovf, bus.out_op); end
    idle(1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0 || count !== 2'd0) begin
      n_err++; $display("FAIL refuse_not_stored: got valid=%b count=%0d expected valid=0 count=0", bus.out_valid, count); end
  endtask

  task automatic test_push_pop_one();
    step(1'b1, 32'h1234_5678, ALU_ADD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFF00_FF00, ALU_AND, 1'b0, 1'b0, 1'b1);
    $display("txn push_pop_one pushed ff00ff00 with pop");
    n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL pp_count: got %0d expected 1", count); end
    n_cmp++; if (bus.out_y !== 32'hFF00_FF00 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL pp_head: got y=%h valid=%b expected y=ff00ff00 valid=1", bus.out_y, bus.out_valid); end
    idle(1'b1);
    n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL pp_drain: got %0d expected 0", count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] y;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 3) != 0, y, 4'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      if (last_push || last_pop)
        $display("txn rnd %0d push=%b pop=%b count=%0d", i, last_push, last_pop, count);
      n_cmp++; if (count !== 2'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, mq.size()); end
      n_cmp++; if (bus.out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.out_valid, mq.size() != 0); end
      n_cmp++; if (bus.in_ready !== (mq.size() != 2)) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, bus.in_ready, mq.size() != 2); end
      n_cmp++; if (pop_cnt !== 16'(m_pops)) begin n_err++; $display("FAIL rnd_pop_cnt[%0d]: got %h expected %h", i, pop_cnt, 16'(m_pops)); end
      if (mq.size() != 0) begin
        n_cmp++;
        if (bus.out_y !== mq[0].y || bus.out_op !== mq[0].op || bus.out_zero !== mq[0].zero ||
            bus.out_neg !== mq[0].neg || bus.out_carry !== mq[0].carry || bus.out_ovf !== mq[0].ovf) begin
          n_err++;
          $display("FAIL rnd_head[%0d]: got y=%h op=%0d z=%b n=%b c=%b v=%b expected y=%h op=%0d z=%b n=%b c=%b v=%b",
                   i, bus.out_y, bus.out_op, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf,
                   mq[0].y, mq[0].op, mq[0].zero, mq[0].neg, mq[0].carry, mq[0].ovf);
        end
      end
    end
    while (mq.size() != 0) idle(1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h0BAD_F00D, ALU_OR, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_0001, ALU_XOR, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL mid_prefill: got %0d expected 2", count); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid asserted with two entries");
    n_cmp++; if (bus.out_valid !== 1'b0 || count !== 2'd0 || pop_cnt !== 16'd0) begin
      n_err++; $display("FAIL mid_reset_state: got valid=%b count=%0d pop_cnt=%h expected 0/0/0000",
                        bus.out_valid, count, pop_cnt); end
    n_cmp++; if (bus.out_y !== 32'd0 || bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_data: got y=%h in_ready=%b expected 00000000/0", bus.out_y, bus.in_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    n_cmp++; if (bus.in_ready !== 1'b1 || count !== 2'd0) begin
      n_err++; $display("FAIL mid_release: got in_ready=%b count=%0d expected 1/0", bus.in_ready, count); end
  endtask

  task automatic test_pop_wrap();
    step(1'b1, $urandom, ALU_ADD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) step(1'b1, $urandom, ALU_ADD, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    $display("txn pop_wrap after 65535 pops pop_cnt=%h", pop_cnt);
    n_cmp++; if (pop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h expected ffff", pop_cnt); end
    step(1'b1, 32'h0000_0001, ALU_SUB, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    $display("txn pop_wrap one more pop pop_cnt=%h", pop_cnt);
    n_cmp++; if (pop_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h expected 0000", pop_cnt); end
    n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL wrap_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_full_refuse();
    test_push_pop_one();
    test_random();
    test_reset_mid();
    test_pop_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of result bus.
REQ-002 Parameter DEPTH, fixed at 2, buffer entries; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-005 in_valid  input  1  upstream unit result (e.g. 32-bit AND array output y) is valid.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_y  input  WIDTH  result word from the bitwise/arith unit.
REQ-008 in_op  input  4  opcode that produced in_y.
REQ-009 in_carry  input  1  carry from unit (0 for bitwise ops).
REQ-010 in_ovf  input  1  signed overflow from unit (0 for bitwise ops).
REQ-011 out_valid  output  1  head entry available downstream.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_y  output  WIDTH  head result word.
REQ-014 out_op  output  4  head opcode.
REQ-015 out_zero / out_neg / out_carry / out_ovf  output  1 each  head flags.
REQ-016 count  output  2  entries held (0..2).
REQ-017 pop_cnt  output  16  results delivered since reset.

Function
REQ-018 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 in_ready = (count != 2); registered/state-derived only, no combinational path from out_ready (full stage refuses push even if popping same cycle).
REQ-020 out_valid = (count != 0); out_* driven from head entry registers, no combinational path from in_*.
REQ-021 Latency: result pushed in cycle N appears on out_* with out_valid in cycle N+1 when stage was empty.
REQ-022 Flags computed at capture: zero = (in_y == 0), neg = in_y[WIDTH-1], carry/ovf copied.
REQ-023 Occupancy FSM states EMPTY, ONE, FULL: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push+pop; FULL->ONE on pop; otherwise hold.
REQ-024 Order strictly FIFO; 1-bit read/write pointers wrap 1->0.
REQ-025 Head entry and flags held stable while out_valid && !out_ready.
REQ-026 Simultaneous push+pop in ONE: head advances to the new entry, count stays 1, no data lost or duplicated.
REQ-027 pop_cnt increments by 1 per pop, wraps 0xFFFF->0x0000 without flag.
REQ-028 in_* ignored when in_ready is 0; out_ready ignored when out_valid is 0.

Reset
REQ-029 rst_n low asynchronously forces state EMPTY, pointers 0, count 0, pop_cnt 0, out_valid 0, in_ready 0 while asserted, all out_* data/flags 0.
REQ-030 in_ready rises in the first clk edge after rst_n deasserts; reset mid-transfer discards buffered entries with no pop counted.

Structure
REQ-031 Shared package alu_pkg holds WIDTH default, opcode constants (ALU_AND=0, ALU_OR=1, ALU_XOR=2, ALU_ADD=3, ALU_SUB=4) and the result-entry record (y, op, zero, neg, carry, ovf).
REQ-032 One sub-module alu_flags (combinational zero/neg generation from in_y); occupancy FSM and storage stay in alu_result_stage.

Verification
REQ-033 Reset then single push in_y=0xA5A5A5A5, op=ALU_AND, out_ready=1 -> next cycle out_y=0xA5A5A5A5, out_neg=1, out_zero=0; following cycle count=0, pop_cnt=1.
REQ-034 out_ready=0, push 0x00000000 then 0xFFFFFFFF -> count=2, in_ready=0, out_y=0x00000000 with out_zero=1 held; raise out_ready -> 0xFFFFFFFF (neg=1) next, order preserved.
REQ-035 Full with in_valid=1 and out_ready=1 same cycle -> push refused (in_y not stored), one pop, count=1.
REQ-036 count=1, simultaneous push 0xFF00FF00 and pop -> count stays 1, out_y=0xFF00FF00 next cycle.
REQ-037 Assert rst_n=0 mid-cycle with count=2 -> outputs zero immediately, pop_cnt=0; after release in_ready=1.
REQ-038 Preload pop_cnt to 0xFFFF via 65535 pops, one more pop -> pop_cnt=0x0000.
